move_interpolator: RTL and testbench

- Downstream consumer of the controller interface stage. Takes one accepted move command: target X/Y plus the 5-bit mode word {tool_change, raise_tool, relative, inches, linear}.
- Walks the tool from its current Cartesian position to the target along a Bresenham line, one unit step per setpoint.
- Hands setpoints, with a valid/ready handshake, to the inverse-kinematics stage.
- Drives controller_ready back upstream so no new command is taken mid-move.

---
 rtl/move_interpolator_if.sv | 26 ++
 rtl/move_interpolator.sv | 223 ++++++++++++++++++++++
 tb/tb_move_interpolator.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_interpolator_if.sv
// Handshake bundle around move_interpolator: upstream command side and
// downstream setpoint side.
interface move_interpolator_if #(
    parameter int unsigned W = 14
);
    logic         cmd_valid;
    logic [4:0]   state_reg;
    logic [W-1:0] x_value;
    logic [W-1:0] y_value;
    logic         controller_ready;
    logic [W-1:0] sp_x;
    logic [W-1:0] sp_y;
    logic         sp_valid;
    logic         sp_ready;

    // Environment view: issues commands and consumes setpoints.
    modport master (
        output cmd_valid, state_reg, x_value, y_value, sp_ready,
        input  controller_ready, sp_x, sp_y, sp_valid
    );

    modport slave (
        input  cmd_valid, state_reg, x_value, y_value, sp_ready,
        output controller_ready, sp_x, sp_y, sp_valid
    );
endinterface

// File: rtl/move_interpolator.sv
// Bresenham move interpolator: turns one accepted move command into a stream
// of unit-step setpoints for the inverse-kinematics stage.
module move_interpolator #(
    parameter int unsigned W        = 14,
    parameter int unsigned HOME_X   = 0,
    parameter int unsigned HOME_Y   = 0,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    move_interpolator_if.slave  bus,
    output logic                pen_up,
    output logic [3:0]          tool_id,
    output logic                tool_change_pulse,
    output logic                busy
);
    localparam int unsigned RW = W + 2;
    localparam int unsigned EW = W + 3;
    localparam int unsigned DW = $clog2(STEP_DIV + 2) + 1;

    localparam int unsigned M_TOOL  = 4;
    localparam int unsigned M_RAISE = 3;
    localparam int unsigned M_REL   = 2;
    localparam int unsigned M_INCH  = 1;
    localparam int unsigned M_LIN   = 0;

    localparam logic [W-1:0] HOME_XC = W'(HOME_X);
    localparam logic [W-1:0] HOME_YC = W'(HOME_Y);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 cmd_prev_q;
    logic                 rel_q, rel_d;
    logic [W-1:0]         val_x_q, val_x_d, val_y_q, val_y_d;
    logic [W-1:0]         tx_q, tx_d, ty_q, ty_d;
    logic [W-1:0]         dx_q, dx_d, dy_q, dy_d;
    logic                 sx_q, sx_d, sy_q, sy_d;
    logic signed [EW-1:0] err_q, err_d;
    logic [DW-1:0]        div_q, div_d;
    logic [W-1:0]         sp_x_q, sp_x_d, sp_y_q, sp_y_d;
    logic                 sp_valid_q, sp_valid_d;
    logic                 pen_up_q, pen_up_d;
    logic [3:0]           tool_id_q, tool_id_d;
    logic                 tc_pulse_q, tc_pulse_d;

    logic                 accept;
    logic                 unused_inches;
    logic [W-1:0]         tgt_x, tgt_y, adx, ady;
    logic signed [EW-1:0] dx_s, dy_s, e2, nx_err;
    logic [W-1:0]         nx_x, nx_y;
    logic                 at_target, div_ok;

    // Absolute targets pass through; relative ones are offset and clamped.
    function automatic logic [W-1:0] resolve(input logic rel,
                                             input logic [W-1:0] pos,
                                             input logic [W-1:0] val);
        logic signed [RW-1:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{2{val[W-1]}}, val});
        if (!rel)
            return val;
        else if (sum[RW-1])
            return '0;
        else if (sum[W])
            return '1;
        else
            return sum[W-1:0];
    endfunction

    assign accept        = bus.cmd_valid & ~cmd_prev_q & (state_q == S_IDLE);
    assign unused_inches = bus.state_reg[M_INCH];

    assign tgt_x = resolve(rel_q, sp_x_q, val_x_q);
    assign tgt_y = resolve(rel_q, sp_y_q, val_y_q);
    assign adx   = (tgt_x >= sp_x_q) ? tgt_x - sp_x_q : sp_x_q - tgt_x;
    assign ady   = (tgt_y >= sp_y_q) ? tgt_y - sp_y_q : sp_y_q - tgt_y;

    assign dx_s      = $signed(EW'(dx_q));
    assign dy_s      = $signed(EW'(dy_q));
    assign e2        = err_q <<< 1;
    assign at_target = (sp_x_q == tx_q) && (sp_y_q == ty_q);
    // Launch edge sits two cycles after the WAIT->STEP decision point.
    assign div_ok    = (32'(div_q) + 32'd2) >= STEP_DIV;

    // One Bresenham iteration from the current point.
    always_comb begin
        nx_x   = sp_x_q;
        nx_y   = sp_y_q;
        nx_err = err_q;
        if (e2 > -dy_s) begin
            nx_err = nx_err - dy_s;
            nx_x   = sx_q ? sp_x_q - W'(1) : sp_x_q + W'(1);
        end
        if (e2 < dx_s) begin
            nx_err = nx_err + dx_s;
            nx_y   = sy_q ? sp_y_q - W'(1) : sp_y_q + W'(1);
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d    = state_q;
        rel_d      = rel_q;
        val_x_d    = val_x_q;
        val_y_d    = val_y_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        err_d      = err_q;
        div_d      = (&div_q) ? div_q : div_q + DW'(1);
        sp_x_d     = sp_x_q;
        sp_y_d     = sp_y_q;
        sp_valid_d = sp_valid_q;
        pen_up_d   = pen_up_q;
        tool_id_d  = tool_id_q;
        tc_pulse_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rel_d   = bus.state_reg[M_REL];
                    val_x_d = bus.x_value;
                    val_y_d = bus.y_value;
                    if (bus.state_reg[M_TOOL]) begin
                        tool_id_d  = bus.x_value[3:0];
                        tc_pulse_d = 1'b1;
                    end else begin
                        pen_up_d = bus.state_reg[M_RAISE];
                        if (bus.state_reg[M_LIN])
                            state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                tx_d    = tgt_x;
                ty_d    = tgt_y;
                dx_d    = adx;
                dy_d    = ady;
                sx_d    = tgt_x < sp_x_q;
                sy_d    = tgt_y < sp_y_q;
                err_d   = $signed(EW'(adx)) - $signed(EW'(ady));
                state_d = ((adx == '0) && (ady == '0)) ? S_IDLE : S_STEP;
            end
            S_STEP: begin
                sp_x_d     = nx_x;
                sp_y_d     = nx_y;
                err_d      = nx_err;
                sp_valid_d = 1'b1;
                div_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (sp_valid_q) begin
                    if (bus.sp_ready) begin
                        sp_valid_d = 1'b0;
                        if (at_target)
                            state_d = S_IDLE;
                        else if (div_ok)
                            state_d = S_STEP;
                    end
                end else if (div_ok) begin
                    state_d = S_STEP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_prev_q <= 1'b0;
            rel_q      <= 1'b0;
            val_x_q    <= '0;
            val_y_q    <= '0;
            tx_q       <= HOME_XC;
            ty_q       <= HOME_YC;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            err_q      <= '0;
            div_q      <= '0;
            sp_x_q     <= HOME_XC;
            sp_y_q     <= HOME_YC;
            sp_valid_q <= 1'b0;
            pen_up_q   <= 1'b0;
            tool_id_q  <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_prev_q <= bus.cmd_valid;
            rel_q      <= rel_d;
            val_x_q    <= val_x_d;
            val_y_q    <= val_y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            err_q      <= err_d;
            div_q      <= div_d;
            sp_x_q     <= sp_x_d;
            sp_y_q     <= sp_y_d;
            sp_valid_q <= sp_valid_d;
            pen_up_q   <= pen_up_d;
            tool_id_q  <= tool_id_d;
            tc_pulse_q <= tc_pulse_d;
        end
    end

    assign bus.controller_ready = (state_q == S_IDLE) & ~reset;
    assign bus.sp_x             = sp_x_q;
    assign bus.sp_y             = sp_y_q;
    assign bus.sp_valid         = sp_valid_q;
    assign pen_up               = pen_up_q;
    assign tool_id              = tool_id_q;
    assign tool_change_pulse    = tc_pulse_q;
    assign busy                 = (state_q != S_IDLE);
endmodule

// File: tb/tb_move_interpolator.sv
// Scoreboard bench for move_interpolator: a line-drawing reference model
// queues expected setpoints, a monitor checks every handshake.
module tb_move_interpolator;
    localparam int unsigned W = 14;
    localparam int HOME_X   = 0;
    localparam int HOME_Y   = 0;
    localparam int STEP_DIV = 4;
    localparam int MAXV     = (1 << W) - 1;

    localparam logic [4:0] M_LIN   = 5'b00001;
    localparam logic [4:0] M_INCH  = 5'b00010;
    localparam logic [4:0] M_REL   = 5'b00100;
    localparam logic [4:0] M_RAISE = 5'b01000;
    localparam logic [4:0] M_TOOL  = 5'b10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pen_up, tool_change_pulse, busy;
    logic [3:0] tool_id;

    move_interpolator_if #(.W(W)) bus();

    move_interpolator #(.W(W), .HOME_X(HOME_X), .HOME_Y(HOME_Y), .STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .reset(reset), .bus(bus), .pen_up(pen_up), .tool_id(tool_id),
        .tool_change_pulse(tool_change_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int exp_x[$], exp_y[$];
    int mx = HOME_X, my = HOME_Y;
    int exp_pen = 0, exp_tool = 0;
    int hs_cnt = 0, cyc = 0, rdy_mode = 0;
    int last_launch = -1, last_x = HOME_X, last_y = HOME_Y;
    int hold_v = 0, hold_x = 0, hold_y = 0, prev_valid = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_ge(input string nm, input longint act, input longint lim);
        n_chk++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", nm, act, lim);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int resolve_ref(input bit rel, input int pos, input int val);
        int v;
        if (!rel) return val;
        v = (val >= (1 << (W - 1))) ? val - (1 << W) : val;
        v = pos + v;
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        return v;
    endfunction

    // Reference line walk: queue every point from (mx,my) to the target.
    task automatic plan_line(input int tx, input int ty);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = iabs(tx - mx); dy = iabs(ty - my);
        sx = (tx >= mx) ? 1 : -1; sy = (ty >= my) ? 1 : -1;
        err = dx - dy; x = mx; y = my;
        while (x != tx || y != ty) begin
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx) begin err += dx; y += sy; end
            exp_x.push_back(x); exp_y.push_back(y);
        end
        mx = tx; my = ty;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        sp_ready_init();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.sp_ready = 1'b1;
                1: bus.sp_ready = 1'b0;
                default: bus.sp_ready = ($urandom_range(0, 99) < 65);
            endcase
        end
    end

    task automatic sp_ready_init();
        bus.sp_ready = 1'b0;
    endtask

    // Monitor: handshakes, hold stability, step size and launch spacing.
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0; prev_valid = 0; last_launch = -1;
            last_x = HOME_X; last_y = HOME_Y;
        end else begin
            if (hold_v != 0)
                chk("hold_stable", {bus.sp_valid, bus.sp_x, bus.sp_y}, {1'b1, W'(hold_x), W'(hold_y)});
            if (bus.sp_valid && prev_valid == 0) begin
                if (last_launch >= 0) chk_ge("launch_gap", cyc - last_launch, STEP_DIV);
                last_launch = cyc;
            end
            if (bus.sp_valid && bus.sp_ready) begin
                if (exp_x.size() == 0) begin
                    chk("unexpected_setpoint", 1, 0);
                end else begin
                    chk("sp_x", bus.sp_x, exp_x[0]);
                    chk("sp_y", bus.sp_y, exp_y[0]);
                    void'(exp_x.pop_front()); void'(exp_y.pop_front());
                end
                chk("step_delta", (iabs(int'(bus.sp_x) - last_x) > iabs(int'(bus.sp_y) - last_y)) ?
                    iabs(int'(bus.sp_x) - last_x) : iabs(int'(bus.sp_y) - last_y), 1);
                chk("ready_low_in_move", bus.controller_ready, 0);
                last_x = bus.sp_x; last_y = bus.sp_y;
                hs_cnt++;
                hold_v = 0;
            end else if (bus.sp_valid) begin
                hold_v = 1; hold_x = bus.sp_x; hold_y = bus.sp_y;
            end else begin
                hold_v = 0;
            end
            prev_valid = bus.sp_valid;
        end
    end

    // Issue one command when ready; keep cmd_valid high for hold+1 edges.
    task automatic issue(input logic [4:0] mode, input int xv, input int yv,
                         input int hold, output int n_exp, output int extra_pulses);
        int t, tx, ty;
        n_exp = 0; extra_pulses = 0; t = 0;
        while (bus.controller_ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.state_reg = mode; bus.x_value = W'(xv); bus.y_value = W'(yv); bus.cmd_valid = 1'b1;
        if (mode[4]) begin
            exp_tool = xv & 15;
        end else begin
            exp_pen = mode[3];
            if (mode[0]) begin
                tx = resolve_ref(mode[2], mx, xv);
                ty = resolve_ref(mode[2], my, yv);
                n_exp = (iabs(tx - mx) > iabs(ty - my)) ? iabs(tx - mx) : iabs(ty - my);
                plan_line(tx, ty);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (mode[4]) begin
            chk("tc_pulse", tool_change_pulse, 1);
            chk("tool_id", tool_id, exp_tool);
        end else if (mode[0]) begin
            chk("ready_low_after_accept", bus.controller_ready, 0);
        end else begin
            chk("pen_up_cmd", pen_up, exp_pen);
        end
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            extra_pulses += tool_change_pulse + bus.sp_valid;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n_exp, input int base);
        int t = 0;
        while ((exp_x.size() != 0 || bus.controller_ready !== 1'b1) && t < 5000) begin
            @(negedge clk); t++;
        end
        if (t >= 5000) chk("move_timeout", 0, 1);
        chk("setpoint_count", hs_cnt - base, n_exp);
        chk("final_x", bus.sp_x, mx);
        chk("final_y", bus.sp_y, my);
        chk("busy_idle", busy, 0);
        chk("pen_up", pen_up, exp_pen);
    endtask

    task automatic move(input logic [4:0] mode, input int xv, input int yv);
        int n, ex, base;
        base = hs_cnt;
        issue(mode, xv, yv, 1, n, ex);
        wait_done(n, base);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ex, base, t, v;
        bus.cmd_valid = 1'b0; bus.state_reg = '0; bus.x_value = '0; bus.y_value = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.controller_ready, 0);
        chk("rst_sp_valid", bus.sp_valid, 0);
        chk("rst_sp_xy", {bus.sp_x, bus.sp_y}, {W'(HOME_X), W'(HOME_Y)});
        chk("rst_flags", {pen_up, tool_id, tool_change_pulse, busy}, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.controller_ready, 1);

        // Directed moves
        rdy_mode = 0;
        move(M_LIN, 3, 1);
        move(M_LIN, 10, 10);
        move(M_LIN | M_REL, (-3) & MAXV, 5);
        move(M_LIN, 5, 0);
        move(M_LIN | M_REL, (-20) & MAXV, 0);

        // Stall the first setpoint; an edge mid-move must be ignored
        rdy_mode = 1; base = hs_cnt;
        issue(M_LIN, 4, 2, 1, n, ex);
        t = 0;
        while (!bus.sp_valid && t < 100) begin @(negedge clk); t++; end
        chk("stall_first_valid", bus.sp_valid, 1);
        @(posedge clk); #1;
        bus.state_reg = M_LIN; bus.x_value = W'(100); bus.y_value = W'(100); bus.cmd_valid = 1'b1;
        @(posedge clk); #1; bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_ready_low", bus.controller_ready, 0);
        chk("stall_no_handshake", hs_cnt - base, 0);
        rdy_mode = 0;
        wait_done(n, base);

        // Tool change with cmd_valid held, then pen-up without motion
        base = hs_cnt;
        issue(M_TOOL, 'h00B, 0, 10, n, ex);
        chk("tc_no_retrigger", ex, 0);
        chk("tool_id_kept", tool_id, 'hB);
        issue(M_RAISE, 0, 0, 1, n, ex);
        wait_done(0, base);

        // Reset during the third setpoint of a 10-step move
        base = hs_cnt;
        issue(M_LIN, 14, 2, 1, n, ex);
        t = 0;
        while (hs_cnt - base < 2 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        while (!bus.sp_valid && t < 400) begin @(negedge clk); t++; end
        chk("third_sp_seen", bus.sp_valid, 1);
        #1; reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.sp_valid, 0);
        chk("mid_rst_home", {bus.sp_x, bus.sp_y}, {W'(HOME_X), W'(HOME_Y)});
        chk("mid_rst_ready", bus.controller_ready, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_after", bus.controller_ready, 1);
        chk("mid_rst_flags", {pen_up, tool_id}, 0);
        exp_x.delete(); exp_y.delete();
        mx = HOME_X; my = HOME_Y; exp_pen = 0; exp_tool = 0;

        // Randomized moves with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0, 1: move(M_LIN | ($urandom_range(0, 1) ? M_RAISE : 5'b0) |
                           ($urandom_range(0, 1) ? M_INCH : 5'b0),
                           $urandom_range(0, 30), $urandom_range(0, 30));
                2: begin
                    v = $urandom_range(0, 24) - 12;
                    move(M_LIN | M_REL, v & MAXV, ($urandom_range(0, 24) - 12) & MAXV);
                end
                default: move(M_LIN | M_REL, (-int'($urandom_range(20, 40))) & MAXV,
                              ($urandom_range(0, 10) - 5) & MAXV);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
